// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception addresses and the IF/ID bundle
// consumed by the decode stage.
package cpu_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;
   localparam logic [31:0] NOP_INST   = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
      logic        bd;
      logic        adel;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble on flush (flush beats stall), hold on stall,
// otherwise capture the fetch-side bundle.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   stall,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= IF_ID_BUBBLE;
      end else if (flush) begin
         q <= IF_ID_BUBBLE;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, addresses the combinational ROM and feeds
// the IF/ID register, with exception > eret > stall > branch > sequential.
module if_stage #(
   parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
   parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
   parameter int unsigned ROM_AW     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_inst,
   input  logic              stall,
   input  logic              exc_redirect,
   input  logic              eret_redirect,
   input  logic [31:0]       epc,
   input  logic              br_taken,
   input  logic [31:0]       br_target,
   input  logic              id_is_branch,
   output logic [31:0]       pc,
   output logic [31:0]       if_id_pc,
   output logic [31:0]       if_id_inst,
   output logic              if_id_valid,
   output logic              if_id_bd,
   output logic              if_id_adel
);

   import cpu_pkg::if_id_t;
   import cpu_pkg::NOP_INST;

   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic        fetch_adel;
   logic        flush;
   if_id_t      fetch_d;
   if_id_t      if_id_q;

   // Upper PC bits never reach the ROM, so out-of-range fetches alias silently.
   assign rom_addr   = pc_q[ROM_AW+1:2];
   assign fetch_adel = (pc_q[1:0] != 2'b00);
   assign flush      = exc_redirect | eret_redirect;

   always_comb begin
      pc_next = pc_q + 32'd4;
      if (exc_redirect) begin
         pc_next = EXC_VECTOR;
      end else if (eret_redirect) begin
         pc_next = epc;
      end else if (stall) begin
         pc_next = pc_q;
      end else if (br_taken) begin
         pc_next = br_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   // A misaligned fetch still produces a live slot: a nop tagged with adel,
   // carrying the faulting PC so it can become EPC downstream.
   always_comb begin
      fetch_d.pc    = pc_q;
      fetch_d.inst  = fetch_adel ? NOP_INST : rom_inst;
      fetch_d.valid = 1'b1;
      fetch_d.bd    = id_is_branch;
      fetch_d.adel  = fetch_adel;
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .flush (flush),
      .d     (fetch_d),
      .q     (if_id_q)
   );

   assign pc          = pc_q;
   assign if_id_pc    = if_id_q.pc;
   assign if_id_inst  = if_id_q.inst;
   assign if_id_valid = if_id_q.valid;
   assign if_id_bd    = if_id_q.bd;
   assign if_id_adel  = if_id_q.adel;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each cycle's expected PC and IF/ID state is
// queued by the driver and popped by an independent monitor after the edge.
module tb_if_stage;

   localparam int EW = 99;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  rom_addr;
   logic [31:0] rom_inst;
   logic        stall;
   logic        exc_redirect;
   logic        eret_redirect;
   logic [31:0] epc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        id_is_branch;
   logic [31:0] pc;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic        if_id_bd;
   logic        if_id_adel;

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // clock / reset
   always #5 clk = ~clk;

   if_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rom_addr      (rom_addr),
      .rom_inst      (rom_inst),
      .stall         (stall),
      .exc_redirect  (exc_redirect),
      .eret_redirect (eret_redirect),
      .epc           (epc),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .id_is_branch  (id_is_branch),
      .pc            (pc),
      .if_id_pc      (if_id_pc),
      .if_id_inst    (if_id_inst),
      .if_id_valid   (if_id_valid),
      .if_id_bd      (if_id_bd),
      .if_id_adel    (if_id_adel)
   );

   function automatic logic [31:0] rom_word(input logic [5:0] a);
      case (a)
         6'd0:    rom_word = 32'h0800_001d;
         6'd2:    rom_word = 32'h401a_6800;
         6'd29:   rom_word = 32'h2408_000F;
         default: rom_word = 32'hC0DE_0000 | {26'd0, a};
      endcase
   endfunction

   always_comb rom_inst = rom_word(rom_addr);

   // driver: apply inputs for the coming edge and queue the state expected after it
   task automatic step(input logic r, input logic s, input logic e, input logic er,
                       input logic [31:0] ep, input logic b, input logic [31:0] t,
                       input logic ib, input logic [31:0] xpc, input logic [31:0] xipc,
                       input logic [31:0] xinst, input logic xv, input logic xbd,
                       input logic xad);
      @(negedge clk);
      rst_n         = r;
      stall         = s;
      exc_redirect  = e;
      eret_redirect = er;
      epc           = ep;
      br_taken      = b;
      br_target     = t;
      id_is_branch  = ib;
      exp_q.push_back({xpc, xipc, xinst, xv, xbd, xad});
   endtask

   task automatic idle(input logic [31:0] xpc, input logic [31:0] xipc,
                       input logic [31:0] xinst, input logic xbd, input logic xad);
      step(1, 0, 0, 0, 0, 0, 0, 0, xpc, xipc, xinst, 1'b1, xbd, xad);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // monitor / scoreboard
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [EW-1:0] x;
         x = exp_q.pop_front();
         chk("pc",          pc,                     x[98:67]);
         chk("rom_addr",    {26'd0, rom_addr},      {26'd0, x[74:69]});
         chk("if_id_pc",    if_id_pc,               x[66:35]);
         chk("if_id_inst",  if_id_inst,             x[34:3]);
         chk("if_id_valid", {31'd0, if_id_valid},   {31'd0, x[2]});
         chk("if_id_bd",    {31'd0, if_id_bd},      {31'd0, x[1]});
         chk("if_id_adel",  {31'd0, if_id_adel},    {31'd0, x[0]});
      end
   end

   initial begin
      rst_n = 0; stall = 0; exc_redirect = 0; eret_redirect = 0;
      epc = 0; br_taken = 0; br_target = 0; id_is_branch = 0;

      // reset state
      step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
      // sequential fetch after reset release
      idle(32'h4, 32'h0, 32'h0800_001d, 0, 0);
      // taken jump to 0x74: the word at 0x4 is the delay slot
      step(1, 0, 0, 0, 0, 1, 32'h74, 1, 32'h74, 32'h4, 32'hC0DE_0001, 1, 1, 0);
      idle(32'h78, 32'h74, 32'h2408_000F, 0, 0);
      idle(32'h7C, 32'h78, 32'hC0DE_001E, 0, 0);
      // 3-cycle stall at 0x7C, branch pulse in the middle ignored
      step(1, 1, 0, 0, 0, 0, 0, 0, 32'h7C, 32'h78, 32'hC0DE_001E, 1, 0, 0);
      step(1, 1, 0, 0, 0, 1, 32'h40, 1, 32'h7C, 32'h78, 32'hC0DE_001E, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 32'h7C, 32'h78, 32'hC0DE_001E, 1, 0, 0);
      idle(32'h80, 32'h7C, 32'hC0DE_001F, 0, 0);
      // untaken branch in ID still marks the delay slot
      step(1, 0, 0, 0, 0, 0, 0, 1, 32'h84, 32'h80, 32'hC0DE_0020, 1, 1, 0);
      // exception while stalled at 0x84: flush wins
      step(1, 1, 1, 0, 0, 0, 0, 0, 32'h08, 32'h0, 32'h0, 0, 0, 0);
      idle(32'h0C, 32'h08, 32'h401a_6800, 0, 0);
      // exception and eret together: exception wins
      step(1, 0, 1, 1, 32'h88, 0, 0, 0, 32'h08, 32'h0, 32'h0, 0, 0, 0);
      // eret alone returns to epc
      step(1, 0, 0, 1, 32'h88, 0, 0, 0, 32'h88, 32'h0, 32'h0, 0, 0, 0);
      idle(32'h8C, 32'h88, 32'hC0DE_0022, 0, 0);
      // misaligned target 0x86
      step(1, 0, 0, 0, 0, 1, 32'h86, 1, 32'h86, 32'h8C, 32'hC0DE_0023, 1, 1, 0);
      idle(32'h8A, 32'h86, 32'h0, 0, 1);
      idle(32'h8E, 32'h8A, 32'h0, 0, 1);
      // target above ROM aliases onto word 0x1D; bd follows id_is_branch only
      step(1, 0, 0, 0, 0, 1, 32'h174, 0, 32'h174, 32'h8E, 32'h0, 1, 0, 1);
      idle(32'h178, 32'h174, 32'h2408_000F, 0, 0);
      // PC wraps modulo 2^32
      step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h178, 32'hC0DE_001E, 1, 0, 0);
      idle(32'h0, 32'hFFFF_FFFC, 32'hC0DE_003F, 0, 0);
      // reset wins over stall and exception
      step(0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
      idle(32'h4, 32'h0, 32'h0800_001d, 0, 0);

      // bounded drain of the scoreboard
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
